brcomp_iter: RTL
================

// Module: brcomp_iter
// PURPOSE
//  Iterative, parametrised branch/magnitude comparator: compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
//  Terminates early on the first unequal chunk; signed or unsigned per request.
//  Serves multi-cycle/area-reduced datapaths where the single-cycle 32-bit compare cone is too deep.
//  Valid/ready handshake on both request and response sides.
// PARAMETERS
//  WIDTH   32  operand width in bits; must be a multiple of CHUNK (elaboration $error otherwise)
//  CHUNK    4  bits compared per cycle; 1 <= CHUNK <= WIDTH
//  (local) NCHUNK = WIDTH/CHUNK; IDXW = max(1,$clog2(NCHUNK))
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      synchronous reset, active-high
//  req_valid_i    in   1      request present
//  req_ready_o    out  1      block idle, request can be accepted
//  rs1_data_i     in   WIDTH  operand A
//  rs2_data_i     in   WIDTH  operand B
//  br_unsigned_i  in   1      1 = unsigned compare, 0 = two's-complement signed
//  resp_valid_o   out  1      result valid; held until taken
//  resp_ready_i   in   1      consumer takes result
//  br_less_o      out  1      A < B
//  br_equal_o     out  1      A == B
//  br_greater_o   out  1      A > B
//  cycles_o       out  IDXW+1 number of SCAN cycles spent on the current result (1..NCHUNK)
// BEHAVIOUR
//  Reset: state IDLE; resp_valid_o, br_less_o, br_equal_o, br_greater_o = 0; cycles_o = 0; req_ready_o = 1 the cycle after reset.
//  Reset mid-operation aborts the compare: no response is issued and captured operands are discarded.
//  FSM IDLE -> SCAN -> DONE -> IDLE. Exactly one transaction in flight; no request/response overlap.
//  IDLE: req_ready_o=1 (combinational from state only).
//   On req_valid_i & req_ready_o: register A,B with bit WIDTH-1 of both XORed with ~br_unsigned_i (signed -> offset binary).
//   idx=NCHUNK-1, cnt=0, go SCAN.
//  SCAN: req_ready_o=0. Each cycle compare chunk idx of A and B (unsigned), cnt++.
//   Chunk differs: latch lt/gt, eq=0, go DONE.
//   Chunk equal and idx==0: eq=1, lt=gt=0, go DONE.
//   Else: idx--.
//  DONE: resp_valid_o=1; flags and cycles_o stable and exactly one-hot (lt/eq/gt).
//   On resp_ready_i: go IDLE and clear resp_valid_o the next cycle. Flags hold their values until the next result.
//  Latency: acceptance at edge t; resp_valid_o rises after edge t+1+k, where k = 1-based position (from MSB) of the first differing chunk, or NCHUNK if equal.
//   Defaults: 2..9 cycles.
//  req_valid_i outside IDLE is ignored; the requester must hold it.
//   Operand inputs are sampled only in the acceptance cycle; later changes have no effect.
//  CHUNK==WIDTH degenerates to a single SCAN cycle.
//   idx never underflows; cnt saturates at NCHUNK by construction.
// STRUCTURE
//  brcomp_pkg: typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} brcomp_state_e; typedef struct packed {lt, eq, gt} brcomp_flags_t.
//  Sub-module cmp_chunk #(CHUNK): combinational unsigned chunk compare (a,b -> lt, eq, gt); one instance fed by the idx-muxed chunks.
//  Top: FSM, operand registers, idx/cnt counters, result registers.
// TESTING
//  1 Reset mid-SCAN (A=0, B=0, signed, rst_i after 3 cycles) -> no resp_valid_o; req_ready_o=1 after reset; next request completes normally.
//  2 A=0x8000_0000, B=0x0000_0001, unsigned -> gt=1, cycles_o=1. Same operands signed -> lt=1, cycles_o=1.
//  3 A=B=0xDEAD_BEEF, signed -> eq=1, cycles_o=8, resp_valid_o 9 cycles after accept.
//  4 A=0x1234_5670, B=0x1234_5671, unsigned -> lt=1, cycles_o=8.
//    Same with A=0xFFFF_FFFF, B=0x0, signed -> lt=1 (-1<0), cycles_o=1.
//  5 Backpressure: resp_ready_i=0 for 5 cycles -> flags stable, req_ready_o=0 throughout, new req_valid_i ignored until taken.
//  6 Params WIDTH=8, CHUNK=1 and WIDTH=16, CHUNK=16: random signed/unsigned sweep vs $signed/$unsigned golden; one-hot flags; cycles_o matches the first differing chunk.

Source files
------------

// File: rtl/brcomp_pkg.sv
// Shared types for the iterative branch/magnitude comparator.
package brcomp_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} brcomp_state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } brcomp_flags_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brcomp_iter_cmp_chunk.sv
// Combinational unsigned compare of one operand chunk.
module cmp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/brcomp_iter.sv
// Iterative comparator: scans CHUNK bits per cycle from the MSB end, stopping
// at the first unequal chunk. Signed operands are compared as offset binary.
module brcomp_iter
  import brcomp_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned CHUNK  = 4,
  localparam int unsigned NCHUNK = WIDTH / CHUNK,
  localparam int unsigned IDXW   = idx_width(NCHUNK)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic            br_unsigned_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic            br_less_o,
  output logic            br_equal_o,
  output logic            br_greater_o,
  output logic [IDXW:0]   cycles_o
);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("brcomp_iter: WIDTH must be a nonzero multiple of CHUNK");
  end

  brcomp_state_e  state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sign_mask;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW:0]    cnt_q;
  brcomp_flags_t    flags_q;
  logic             resp_valid_q;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_lt, c_eq, c_gt;
  logic             accept, last_chunk, scan_end, resp_take;

  // Flipping both MSBs maps two's complement onto offset binary, so a plain
  // unsigned chunk compare yields the signed ordering.
  always_comb begin
    sign_mask            = '0;
    sign_mask[WIDTH-1]   = ~br_unsigned_i;
  end

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  always_comb begin
    accept     = (state_q == ST_IDLE) && req_valid_i;
    last_chunk = (idx_q == '0);
    scan_end   = (state_q == ST_SCAN) && (!c_eq || last_chunk);
    resp_take  = resp_valid_q && resp_ready_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_i) state_d = ST_SCAN;
      ST_SCAN: if (!c_eq || last_chunk) state_d = ST_DONE;
      ST_DONE: if (resp_take) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // resp_valid is registered off DONE, adding one cycle after the final scan.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      flags_q      <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_q == ST_DONE) && !resp_take;
      if (accept) begin
        a_q   <= rs1_data_i ^ sign_mask;
        b_q   <= rs2_data_i ^ sign_mask;
        idx_q <= IDXW'(NCHUNK - 1);
        cnt_q <= '0;
      end
      if (state_q == ST_SCAN) begin
        cnt_q <= cnt_q + 1'b1;
        if (!last_chunk) idx_q <= idx_q - 1'b1;
      end
      if (scan_end) begin
        flags_q <= '{lt: c_lt, eq: c_eq, gt: c_gt};
      end
    end
  end

  always_comb begin
    req_ready_o  = (state_q == ST_IDLE);
    resp_valid_o = resp_valid_q;
    br_less_o    = flags_q.lt;
    br_equal_o   = flags_q.eq;
    br_greater_o = flags_q.gt;
    cycles_o     = cnt_q;
  end

endmodule
